pc_sequencer: RTL

Next-PC controller for the MCU fetch stage. It sequences the program counter register: it drives the register's next-value input every cycle and owns the instruction-fetch request. It arbitrates between sequential advance, branch, jump, interrupt entry and interrupt return, and holds the exception return address (EPC). It sits between decode/hazard logic, the interrupt source and the PC register, whose output it reads back.

---
 rtl/mcu_pc_pkg.sv | 18 +
 rtl/pc_trap_ctrl.sv | 43 ++++
 rtl/pc_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/mcu_pc_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package mcu_pc_pkg;

  typedef logic [1:0] pc_state_t;

  localparam pc_state_t ST_BOOT = 2'd0;
  localparam pc_state_t ST_RUN  = 2'd1;
  localparam pc_state_t ST_TRAP = 2'd2;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_trap_ctrl.sv
// Interrupt bookkeeping: pending latch, interrupt enable and saved return address.
module pc_trap_ctrl
  import mcu_pc_pkg::*;
#(
  parameter logic IE_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_irq,
  input  logic        i_accept,
  input  logic        i_eret,
  input  logic [31:0] i_ret_addr,
  output logic        o_irq_pending,
  output logic        o_ie,
  output logic [31:0] o_epc
);

  logic        r_pending;
  logic        r_ie;
  logic [31:0] r_epc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_ie      <= IE_RESET;
      r_epc     <= 32'h0;
    end else begin
      // A still-asserted level request re-arms the latch in the acceptance cycle.
      if (i_accept) r_pending <= 1'b0;
      if (i_irq)    r_pending <= 1'b1;

      if (i_accept)    r_ie <= 1'b0;
      else if (i_eret) r_ie <= 1'b1;

      if (i_accept) r_epc <= word_align(i_ret_addr);
    end
  end

  assign o_irq_pending = r_pending;
  assign o_ie          = r_ie;
  assign o_epc         = r_epc;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates sequential, branch, jump, interrupt entry and
// return, and drives the PC register input and the fetch request.
module pc_sequencer
  import mcu_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
  parameter logic        IE_RESET     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        eret,
  input  logic        irq,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic        flush,
  output logic        irq_ack,
  output logic [31:0] epc,
  output logic        ie
);

  pc_state_t   r_state;
  pc_state_t   w_state_d;
  logic        w_advance;
  logic        w_accept;
  logic        w_eret_fire;
  logic        w_irq_pending;
  logic [31:0] w_pc_inc;

  assign w_advance = imem_ready & ~stall;
  assign w_pc_inc  = pc + PC_STEP;

  pc_trap_ctrl #(
    .IE_RESET (IE_RESET)
  ) u_trap_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_irq         (irq),
    .i_accept      (w_accept),
    .i_eret        (w_eret_fire),
    .i_ret_addr    (w_pc_inc),
    .o_irq_pending (w_irq_pending),
    .o_ie          (ie),
    .o_epc         (epc)
  );

  always_comb begin
    w_state_d   = r_state;
    pc_next     = pc;
    imem_req    = 1'b0;
    flush       = 1'b0;
    irq_ack     = 1'b0;
    w_accept    = 1'b0;
    w_eret_fire = 1'b0;
    case (r_state)
      ST_BOOT: begin
        pc_next   = word_align(RESET_VECTOR);
        w_state_d = ST_RUN;
      end
      ST_RUN: begin
        imem_req = 1'b1;
        if (w_advance) begin
          // Redirects outrank interrupt entry; the request stays pending.
          if (eret) begin
            pc_next     = epc;
            flush       = 1'b1;
            w_eret_fire = 1'b1;
          end else if (jump) begin
            pc_next = word_align(jump_target);
            flush   = 1'b1;
          end else if (branch_taken) begin
            pc_next = word_align(branch_target);
            flush   = 1'b1;
          end else if (w_irq_pending && ie) begin
            pc_next   = word_align(TRAP_VECTOR);
            flush     = 1'b1;
            irq_ack   = 1'b1;
            w_accept  = 1'b1;
            w_state_d = ST_TRAP;
          end else begin
            pc_next = w_pc_inc;
          end
        end
      end
      ST_TRAP: begin
        w_state_d = ST_RUN;
      end
      default: begin
        w_state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_d;
  end

endmodule
